sram_controller: RTL and testbench
==================================

Name: sram_controller

Overview:
- Data-memory backend sitting directly downstream of the MEM stage.
- Converts the stage's single-cycle 32-bit word read/write request into two sequential 16-bit accesses on an external asynchronous SRAM.
- Deasserts `ready` while an access is in flight. The top level ORs `!ready` into the pipeline freeze so that IF/ID/EXE/MEM registers hold.

Parameters:
- BASE_ADDR, 1024: byte address of data-memory word 0; subtracted from the request address.
- HALF_CYCLES, 2: clock cycles each 16-bit phase is held on the SRAM bus; legal range 1..15.
- SRAM_ADDR_WIDTH, 18: SRAM halfword address width.

Ports:
- clk  in  1  system clock, rising edge
- rst  in  1  synchronous, active-high reset
- rd_en  in  1  word read request from MEM stage
- wr_en  in  1  word write request from MEM stage
- address  in  32  byte address (ALU result)
- write_data  in  32  store data (val_Rm)
- read_data  out  32  loaded word
- ready  out  1  high = pipeline may advance
- sram_addr  out  SRAM_ADDR_WIDTH  SRAM halfword address
- sram_dq_out  out  16  write data to SRAM
- sram_dq_in  in  16  read data from SRAM
- sram_dq_oe  out  1  drive enable for the top-level tristate
- sram_we_n  out  1  SRAM write strobe, active low
- sram_oe_n  out  1  SRAM output enable, active low

Behaviour:
- Clock and reset: one clock `clk`. `rst` is synchronous and active-high.
- Reset state: state=IDLE, phase counter=0, read_data=0.
  - Bus outputs in IDLE: sram_addr=0, sram_dq_out=0, sram_dq_oe=0, sram_we_n=1, sram_oe_n=1.
  - ready=1 while no request is present.
- Request latching:
  - offset = address - BASE_ADDR (32-bit, wrap allowed).
  - word index = offset[SRAM_ADDR_WIDTH:2], truncated. No range check; out-of-range addresses wrap modulo the SRAM size.
  - Low half uses halfword address {index,0}; high half uses {index,1}.
  - address, write_data and the request type are registered on IDLE exit. Changes to the inputs during the access are ignored.
- FSM states: IDLE, LOW, HIGH, DONE.
  - IDLE → LOW when rd_en|wr_en. If both are high, the access is a write (wr_en priority).
  - LOW lasts exactly HALF_CYCLES cycles (counter 0..HALF_CYCLES-1), then → HIGH with counter reset.
  - HIGH lasts exactly HALF_CYCLES cycles, then → DONE.
  - DONE lasts exactly one cycle, then → IDLE unconditionally. A request still asserted in the following IDLE cycle starts a new access; the pipeline has advanced, so this is the next instruction.
- ready (combinational): ready = (IDLE & !rd_en & !wr_en) | DONE.
  - Request first seen in cycle T: ready=0 for cycles T..T+2·HALF_CYCLES, ready=1 in cycle T+2·HALF_CYCLES+1 (DONE).
  - Default latency: ready returns on the 5th cycle after T.
- Read access:
  - sram_oe_n=0, sram_we_n=1, sram_dq_oe=0 in LOW and HIGH.
  - read_data[15:0] ← sram_dq_in on the last LOW cycle.
  - read_data[31:16] ← sram_dq_in on the last HIGH cycle.
  - read_data is valid in DONE and holds until the next read capture. Writes never modify it.
- Write access:
  - sram_dq_oe=1 and sram_oe_n=1 in LOW and HIGH.
  - sram_dq_out = write_data[15:0] in LOW, [31:16] in HIGH.
  - sram_we_n=0 in every LOW/HIGH cycle except the last cycle of each phase, where it is 1. This gives a data/address hold edge; with HALF_CYCLES=1, sram_we_n stays 0 for the single cycle.
- DONE and IDLE: sram_addr holds its last value in DONE; bus controls return to their idle values.
- Reset mid-access: FSM returns to IDLE on the next edge. The partial write is abandoned (the SRAM may hold the low half only) and read_data clears to 0.

Test Plan:
- Reset: assert rst for 2 cycles mid-HIGH of a write → next cycle state IDLE, ready=1, sram_we_n=1, sram_dq_oe=0, read_data=0.
- Write then read, HALF_CYCLES=2:
  - Write address=1028, write_data=0xDEADBEEF → sram_addr=2 for 2 cycles with dq_out=0xBEEF, then sram_addr=3 with 0xDEAD. sram_we_n pattern per phase is 0,1. ready low 5 cycles, high on the 6th.
  - Then rd_en at 1028 with the SRAM model → read_data=0xDEADBEEF in DONE.
- Latency sweep: HALF_CYCLES=1 and 4 → ready returns 3 and 9 cycles after request, respectively.
- Back-to-back: rd_en held high across DONE → exactly one DONE pulse per access; second access starts in the IDLE cycle after DONE with the newly presented address.
- Simultaneous rd_en=wr_en=1 at address 1024 with data 0x00010002 → write performed (sram_dq_oe=1, halfwords 0x0002 then 0x0001 at sram_addr 0,1); read_data unchanged.
- Input change mid-access: address switched from 1032 to 2000 during LOW → sram_addr stays 4 then 5.

Source files
------------

// File: rtl/sram_controller.sv
// Data-memory backend: splits one 32-bit word access from the MEM stage into
// two timed 16-bit phases on an external asynchronous SRAM, holding ready low meanwhile.
module sram_controller #(
  parameter int BASE_ADDR       = 1024,
  parameter int HALF_CYCLES     = 2,
  parameter int SRAM_ADDR_WIDTH = 18
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       rd_en,
  input  logic                       wr_en,
  input  logic [31:0]                address,
  input  logic [31:0]                write_data,
  output logic [31:0]                read_data,
  output logic                       ready,
  output logic [SRAM_ADDR_WIDTH-1:0] sram_addr,
  output logic [15:0]                sram_dq_out,
  input  logic [15:0]                sram_dq_in,
  output logic                       sram_dq_oe,
  output logic                       sram_we_n,
  output logic                       sram_oe_n
);

  // state | meaning
  // IDLE  | no access; accepts a request, ready when none is present
  // LOW   | low halfword on the bus for HALF_CYCLES cycles
  // HIGH  | high halfword on the bus for HALF_CYCLES cycles
  // DONE  | one-cycle completion; ready=1 and read_data valid

  localparam int IDX_W = SRAM_ADDR_WIDTH - 1;

  typedef enum logic [1:0] {IDLE, LOW, HIGH, DONE} state_t;

  state_t            state, state_nxt;
  logic [3:0]        cnt, cnt_nxt;
  logic [IDX_W-1:0]  idx;
  logic [31:0]       wdata;
  logic              is_wr;
  logic [31:0]       offset;
  logic              last;
  logic              hi;

  assign offset = address - 32'(BASE_ADDR);
  assign last   = (cnt == 4'(HALF_CYCLES - 1));
  assign hi     = (state == HIGH);

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      cnt       <= '0;
      read_data <= '0;
      idx       <= '0;
      wdata     <= '0;
      is_wr     <= 1'b0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
      if (state == IDLE && (rd_en || wr_en)) begin
        idx   <= offset[SRAM_ADDR_WIDTH:2];
        wdata <= write_data;
        is_wr <= wr_en;
      end
      // capture on the final cycle of each phase so SRAM access time is maximised
      if (!is_wr && last) begin
        if (state == LOW)  read_data[15:0]  <= sram_dq_in;
        if (state == HIGH) read_data[31:16] <= sram_dq_in;
      end
    end
  end

  always_comb begin
    state_nxt   = state;
    cnt_nxt     = cnt;
    ready       = 1'b0;
    sram_addr   = '0;
    sram_dq_out = '0;
    sram_dq_oe  = 1'b0;
    sram_we_n   = 1'b1;
    sram_oe_n   = 1'b1;
    case (state)
      IDLE: begin
        ready = !rd_en && !wr_en;
        if (rd_en || wr_en) begin
          state_nxt = LOW;
          cnt_nxt   = '0;
        end
      end
      LOW, HIGH: begin
        sram_addr = {idx, hi};
        if (is_wr) begin
          sram_dq_oe  = 1'b1;
          sram_dq_out = hi ? wdata[31:16] : wdata[15:0];
          // release the strobe one cycle early for address/data hold, unless the phase is one cycle
          sram_we_n   = last && (HALF_CYCLES > 1);
        end else begin
          sram_oe_n = 1'b0;
        end
        if (last) begin
          cnt_nxt   = '0;
          state_nxt = hi ? DONE : HIGH;
        end else begin
          cnt_nxt = cnt + 4'd1;
        end
      end
      DONE: begin
        ready     = 1'b1;
        sram_addr = {idx, 1'b1};
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

endmodule

// File: tb/tb_sram_controller.sv
// Bench for sram_controller: SRAM model, beat/read scoreboards, plus
// HALF_CYCLES=1 and =4 instances sharing the request inputs for latency checks.
module tb_sram_controller;

  logic        clk = 1'b0;
  logic        rst;
  logic        rd_en, wr_en;
  logic [31:0] address, write_data;
  logic [31:0] read_data, read_data_1, read_data_4;
  logic        ready, ready_1, ready_4;
  logic [17:0] sram_addr, sram_addr_1, sram_addr_4;
  logic [15:0] sram_dq_out, sram_dq_out_1, sram_dq_out_4;
  logic [15:0] sram_dq_in;
  logic        sram_dq_oe, sram_dq_oe_1, sram_dq_oe_4;
  logic        sram_we_n, sram_we_n_1, sram_we_n_4;
  logic        sram_oe_n, sram_oe_n_1, sram_oe_n_4;

  int n_tests = 0;
  int n_fail  = 0;

  logic [15:0] mem [0:255];
  logic [34:0] beat_q [$];
  logic [31:0] rd_q [$];
  logic        prev_oe_n = 1'b1;

  always #5 clk = ~clk;

  sram_controller #(.BASE_ADDR(1024), .HALF_CYCLES(2), .SRAM_ADDR_WIDTH(18)) u_dut (
    .clk(clk), .rst(rst), .rd_en(rd_en), .wr_en(wr_en), .address(address),
    .write_data(write_data), .read_data(read_data), .ready(ready),
    .sram_addr(sram_addr), .sram_dq_out(sram_dq_out), .sram_dq_in(sram_dq_in),
    .sram_dq_oe(sram_dq_oe), .sram_we_n(sram_we_n), .sram_oe_n(sram_oe_n));

  sram_controller #(.BASE_ADDR(1024), .HALF_CYCLES(1), .SRAM_ADDR_WIDTH(18)) u_hc1 (
    .clk(clk), .rst(rst), .rd_en(rd_en), .wr_en(wr_en), .address(address),
    .write_data(write_data), .read_data(read_data_1), .ready(ready_1),
    .sram_addr(sram_addr_1), .sram_dq_out(sram_dq_out_1), .sram_dq_in(sram_dq_in),
    .sram_dq_oe(sram_dq_oe_1), .sram_we_n(sram_we_n_1), .sram_oe_n(sram_oe_n_1));

  sram_controller #(.BASE_ADDR(1024), .HALF_CYCLES(4), .SRAM_ADDR_WIDTH(18)) u_hc4 (
    .clk(clk), .rst(rst), .rd_en(rd_en), .wr_en(wr_en), .address(address),
    .write_data(write_data), .read_data(read_data_4), .ready(ready_4),
    .sram_addr(sram_addr_4), .sram_dq_out(sram_dq_out_4), .sram_dq_in(sram_dq_in),
    .sram_dq_oe(sram_dq_oe_4), .sram_we_n(sram_we_n_4), .sram_oe_n(sram_oe_n_4));

  // asynchronous SRAM model driven by the main instance
  always @(posedge clk)
    if (sram_dq_oe && !sram_we_n) mem[sram_addr[7:0]] <= sram_dq_out;
  assign sram_dq_in = mem[sram_addr[7:0]];

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // write beats ({we_n, addr, dq}) and completed reads are compared as they appear
  always @(negedge clk) begin
    if (sram_dq_oe === 1'b1) begin
      if (beat_q.size() > 0) check("wr_beat", {sram_we_n, sram_addr, sram_dq_out}, beat_q.pop_front());
      else check("wr_beat_unexpected", {sram_we_n, sram_addr, sram_dq_out}, 64'h0);
    end
    if (prev_oe_n === 1'b0 && sram_oe_n === 1'b1 && ready === 1'b1 && rd_q.size() > 0)
      check("rd_sb", read_data, rd_q.pop_front());
    prev_oe_n = sram_oe_n;
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic push_wr(input logic [17:0] lo, input logic [31:0] d);
    beat_q.push_back({1'b0, lo, d[15:0]});
    beat_q.push_back({1'b1, lo, d[15:0]});
    beat_q.push_back({1'b0, lo + 18'd1, d[31:16]});
    beat_q.push_back({1'b1, lo + 18'd1, d[31:16]});
  endtask

  // called just after a rising edge; returns at the DONE cycle's falling edge
  task automatic do_access(input logic rd, input logic wr, input logic [31:0] a,
                           input logic [31:0] d, output int lat);
    rd_en = rd; wr_en = wr; address = a; write_data = d; lat = 0;
    @(negedge clk);
    while (!ready && lat < 40) begin
      step();
      rd_en = 1'b0; wr_en = 1'b0;
      lat++;
      @(negedge clk);
    end
  endtask

  task automatic sweep(input logic rd, input logic wr);
    int l1, l4;
    l1 = -1; l4 = -1;
    rd_en = rd; wr_en = wr; address = 32'd1028; write_data = 32'hDEADBEEF;
    for (int c = 0; c < 12; c++) begin
      @(negedge clk);
      if (ready_1 && l1 < 0) l1 = c;
      if (ready_4 && l4 < 0) l4 = c;
      if (wr && (c == 1 || c == 2)) check("hc1_we_n", sram_we_n_1, 1'b0);
      if (wr && c == 2) check("hc1_dq_hi", sram_dq_out_1, 16'hDEAD);
      step();
      if (c == 0) begin rd_en = 1'b0; wr_en = 1'b0; end
    end
    check("hc1_lat", l1, 3);
    check("hc4_lat", l4, 9);
  endtask

  initial begin
    int lat, dones, last_done;
    rst = 1'b1; rd_en = 1'b0; wr_en = 1'b0; address = '0; write_data = '0;
    @(posedge clk);
    step();
    rst = 1'b0;
    @(negedge clk);
    check("rst_ready", ready, 1'b1);
    check("rst_bus", {sram_addr, sram_dq_out, sram_dq_oe, sram_we_n, sram_oe_n},
          {18'd0, 16'd0, 1'b0, 1'b1, 1'b1});
    check("rst_rdata", read_data, 32'h0);
    step();

    push_wr(18'd2, 32'hDEADBEEF);
    do_access(1'b0, 1'b1, 32'd1028, 32'hDEADBEEF, lat);
    check("wr_lat", lat, 5);
    step();

    rd_q.push_back(32'hDEADBEEF);
    do_access(1'b1, 1'b0, 32'd1028, 32'h0, lat);
    check("rd_lat", lat, 5);
    check("rd_data", read_data, 32'hDEADBEEF);
    step();

    // inputs switched mid-access must not affect the bus
    push_wr(18'd4, 32'hCAFEF00D);
    wr_en = 1'b1; address = 32'd1032; write_data = 32'hCAFEF00D;
    step();
    wr_en = 1'b0; address = 32'd2000; write_data = 32'h55555555;
    @(negedge clk);
    check("mid_addr_lo", sram_addr, 18'd4);
    lat = 1;
    while (!ready && lat < 40) begin
      @(negedge clk);
      lat++;
    end
    check("mid_lat", lat, 5);
    step();

    // rd_en held through DONE: second access picks up the new address
    rd_q.push_back(32'hDEADBEEF);
    rd_q.push_back(32'hCAFEF00D);
    rd_en = 1'b1; address = 32'd1028;
    dones = 0; last_done = -1;
    for (int c = 0; c < 12; c++) begin
      @(negedge clk);
      if (ready) begin dones++; last_done = c; end
      if (c == 7) check("b2b_addr", sram_addr, 18'd4);
      step();
      if (dones == 1) address = 32'd1032;
      if (dones == 2) rd_en = 1'b0;
    end
    check("b2b_dones", dones, 2);
    check("b2b_done2", last_done, 11);
    check("b2b_rdata", read_data, 32'hCAFEF00D);

    push_wr(18'd0, 32'h00010002);
    do_access(1'b1, 1'b1, 32'd1024, 32'h00010002, lat);
    check("both_lat", lat, 5);
    check("both_rdata", read_data, 32'hCAFEF00D);
    step();

    repeat (12) step();
    rd_q.push_back(32'hDEADBEEF);
    sweep(1'b1, 1'b0);
    repeat (12) step();
    push_wr(18'd2, 32'hDEADBEEF);
    sweep(1'b0, 1'b1);
    repeat (12) step();

    // reset during the HIGH phase of a write
    beat_q.push_back({1'b0, 18'd6, 16'h2222});
    beat_q.push_back({1'b1, 18'd6, 16'h2222});
    beat_q.push_back({1'b0, 18'd7, 16'h1111});
    wr_en = 1'b1; address = 32'd1036; write_data = 32'h11112222;
    step();
    wr_en = 1'b0;
    step();
    step();
    rst = 1'b1;
    step();
    @(negedge clk);
    check("mid_rst_ready", ready, 1'b1);
    check("mid_rst_bus", {sram_dq_oe, sram_we_n, sram_oe_n}, 3'b011);
    check("mid_rst_rdata", read_data, 32'h0);
    step();
    rst = 1'b0;
    repeat (3) step();

    check("beat_q_empty", beat_q.size(), 0);
    check("rd_q_empty", rd_q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1);
  end

endmodule
